// File: rtl/kernel_pkg.sv
// Shared constants, fetch state type and kernel address helper for the
// kernel coefficient fetch unit.
package kernel_pkg;

    localparam int WIDTH    = 24;
    localparam int KSIZE    = 9;
    localparam int NKERNELS = 3;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        ERR
    } fetch_state_t;

    // Word offset of the first coefficient of kernel 'sel' from the base address.
    function automatic int kernel_offset(input int sel, input int ksize = KSIZE);
        return sel * ksize;
    endfunction

endpackage

// File: rtl/kernel_addr_gen.sv
// Word counter plus base/offset adder that walks the coefficients of the
// selected kernel and flags the final word.
module kernel_addr_gen #(
    parameter int WIDTH     = kernel_pkg::WIDTH,
    parameter int KSIZE     = kernel_pkg::KSIZE,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         step,
    input  logic [1:0]                   sel,
    output logic [WIDTH-1:0]             addr,
    output logic [kernel_pkg::CNT_W-1:0] count,
    output logic                         last
);
    import kernel_pkg::*;

    logic [1:0] sel_q;

    // The kernel index is frozen at acceptance so the address stays stable
    // even if kernel_sel changes during the walk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            sel_q <= '0;
        end else if (load) begin
            count <= '0;
            sel_q <= sel;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    assign addr = WIDTH'(BASE_ADDR)
                + WIDTH'(kernel_offset(int'(sel_q), KSIZE))
                + WIDTH'(count);
    assign last = (count == CNT_W'(KSIZE - 1));

endmodule

// File: rtl/kernel_fetch.sv
// Read-only fetch of one 3x3 convolution kernel from data memory into a
// coefficient buffer, with start/busy/done/error handshake.
module kernel_fetch #(
    parameter int WIDTH     = kernel_pkg::WIDTH,
    parameter int KSIZE     = kernel_pkg::KSIZE,
    parameter int NKERNELS  = kernel_pkg::NKERNELS,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             kernel_sel,
    output logic [WIDTH-1:0]       mem_addr,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_wd,
    input  logic [WIDTH-1:0]       mem_rd,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   kernel_valid,
    output logic [KSIZE*WIDTH-1:0] coef
);
    import kernel_pkg::*;

    fetch_state_t                 state;
    fetch_state_t                 next_state;
    logic                         sel_ok;
    logic                         accept;
    logic                         last;
    logic [CNT_W-1:0]             count;
    logic [WIDTH-1:0]             addr;
    logic [KSIZE-1:0][WIDTH-1:0]  coef_q;

    assign sel_ok = (int'(kernel_sel) < NKERNELS);
    assign accept = (state == IDLE) && start && sel_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start is only honoured in IDLE; requests in any other state are dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = sel_ok ? FETCH : ERR;
            FETCH:   if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        case (state)
            FETCH:   busy  = 1'b1;
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    kernel_addr_gen #(
        .WIDTH     (WIDTH),
        .KSIZE     (KSIZE),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (busy && !last),
        .sel   (kernel_sel),
        .addr  (addr),
        .count (count),
        .last  (last)
    );

    // Valid is withdrawn at acceptance and only restored once the last word
    // lands, so a reset or partial walk never exposes a mixed kernel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef_q       <= '0;
            kernel_valid <= 1'b0;
        end else if (accept) begin
            kernel_valid <= 1'b0;
        end else if (busy) begin
            coef_q[count] <= mem_rd;
            if (last) begin
                kernel_valid <= 1'b1;
            end
        end
    end

    assign coef     = coef_q;
    assign mem_addr = busy ? addr : '0;
    assign mem_we   = 1'b0;
    assign mem_wd   = '0;

endmodule

// File: tb/tb_kernel_fetch.sv
// Self-checking bench for kernel_fetch: directed scenarios on the production
// kernels followed by randomized fetches against a memory-based model.
module tb_kernel_fetch;

    localparam int WIDTH     = 24;
    localparam int KSIZE     = 9;
    localparam int NKERNELS  = 3;
    localparam int BASE_ADDR = 0;
    localparam int MEMWORDS  = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [1:0]             kernel_sel;
    logic [WIDTH-1:0]       mem_addr;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_wd;
    logic [WIDTH-1:0]       mem_rd;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic                   kernel_valid;
    logic [KSIZE*WIDTH-1:0] coef;

    logic [WIDTH-1:0]       mem [MEMWORDS];
    int                     addr_trace[$];
    int                     total = 0;
    int                     bad = 0;

    kernel_fetch #(
        .WIDTH     (WIDTH),
        .KSIZE     (KSIZE),
        .NKERNELS  (NKERNELS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .kernel_sel   (kernel_sel),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .kernel_valid (kernel_valid),
        .coef         (coef)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_addr < MEMWORDS) ? mem[mem_addr[5:0]] : 24'hBADBAD;

    // Write port must stay idle and the address parked at 0 outside fetches.
    always @(negedge clk) begin
        total++;
        if (mem_we !== 1'b0 || mem_wd !== '0) begin
            bad++;
            $display("[TB] FAIL write_port: we=%b wd=%h, required we=0 wd=0", mem_we, mem_wd);
        end
        total++;
        if (busy !== 1'b1 && mem_addr !== '0) begin
            bad++;
            $display("[TB] FAIL idle_addr: mem_addr=%0d, required 0", mem_addr);
        end
        if (busy === 1'b1) addr_trace.push_back(int'(mem_addr));
    end

    task automatic load_production();
        for (int i = 0; i < MEMWORDS; i++) mem[i] = WIDTH'($urandom);
        for (int i = 0; i < KSIZE; i++) mem[BASE_ADDR + i] = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        mem[BASE_ADDR + 4] = 24'h000005;
        for (int i = 0; i < KSIZE; i++) mem[BASE_ADDR + KSIZE + i] = 24'hFFFFFF;
        mem[BASE_ADDR + KSIZE + 4] = 24'h000009;
        for (int i = 0; i < KSIZE; i++) mem[BASE_ADDR + 2 * KSIZE + i] = 24'h000000;
    endtask

    function automatic logic [KSIZE*WIDTH-1:0] model_kernel(input int sel);
        logic [KSIZE*WIDTH-1:0] v;
        for (int i = 0; i < KSIZE; i++) v[i*WIDTH +: WIDTH] = mem[BASE_ADDR + sel * KSIZE + i];
        return v;
    endfunction

    function automatic bit trace_ok(input int sel);
        bit ok;
        ok = (addr_trace.size() == KSIZE);
        for (int i = 0; i < addr_trace.size(); i++)
            if (addr_trace[i] != BASE_ADDR + sel * KSIZE + i) ok = 1'b0;
        return ok;
    endfunction

    // Issue a one-cycle start and watch until done or the cycle budget runs out.
    task automatic run_fetch(input logic [1:0] sel, output int done_at,
                             output logic valid_first, output logic valid_done);
        done_at     = -1;
        valid_first = 1'bx;
        valid_done  = 1'b0;
        @(negedge clk);
        addr_trace.delete();
        start      = 1'b1;
        kernel_sel = sel;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) valid_first = kernel_valid;
            if (done === 1'b1) begin
                done_at    = k;
                valid_done = kernel_valid;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, error, kernel_valid} !== 4'b0 || coef !== '0 || mem_addr !== '0) begin
            bad++;
            $display("[TB] FAIL reset_in: b/d/e/v=%b coef=%h addr=%0d, required all 0",
                     {busy, done, error, kernel_valid}, coef, mem_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, error, kernel_valid} !== 4'b0 || coef !== '0) begin
            bad++;
            $display("[TB] FAIL reset_out: b/d/e/v=%b coef=%h, required all 0",
                     {busy, done, error, kernel_valid}, coef);
        end
    endtask

    task automatic test_kernel0();
        int done_at;
        logic vf, vd;
        logic [KSIZE*WIDTH-1:0] expected;
        expected = {24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h000005,
                    24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0};
        run_fetch(2'd0, done_at, vf, vd);
        total++;
        if (done_at != 10) begin
            bad++;
            $display("[TB] FAIL k0_latency: done at cycle %0d, required 10", done_at);
        end
        total++;
        if (!trace_ok(0)) begin
            bad++;
            $display("[TB] FAIL k0_addr: %0d addresses seen, required 0..8", addr_trace.size());
        end
        total++;
        if (coef !== expected) begin
            bad++;
            $display("[TB] FAIL k0_coef: got %h, required %h", coef, expected);
        end
        total++;
        if (vd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL k0_valid: kernel_valid=%b at done, required 1", vd);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL k0_pulse: done=%b busy=%b after done cycle, required 0 0", done, busy);
        end
    endtask

    task automatic test_kernel1();
        int done_at;
        logic vf, vd;
        logic [KSIZE*WIDTH-1:0] expected;
        expected = {{4{24'hFFFFFF}}, 24'h000009, {4{24'hFFFFFF}}};
        run_fetch(2'd1, done_at, vf, vd);
        total++;
        if (done_at != 10 || !trace_ok(1)) begin
            bad++;
            $display("[TB] FAIL k1_addr: done at %0d with %0d addresses, required 10 and 9..17",
                     done_at, addr_trace.size());
        end
        total++;
        if (coef !== expected) begin
            bad++;
            $display("[TB] FAIL k1_coef: got %h, required %h", coef, expected);
        end
        total++;
        if (vf !== 1'b0 || vd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL k1_valid: valid after start=%b at done=%b, required 0 1", vf, vd);
        end
    endtask

    task automatic test_kernel2_and_error();
        int done_at;
        logic vf, vd;
        run_fetch(2'd2, done_at, vf, vd);
        total++;
        if (done_at != 10 || !trace_ok(2) || coef !== '0) begin
            bad++;
            $display("[TB] FAIL k2_fetch: done at %0d, %0d addresses, coef=%h, required 10, 18..26, 0",
                     done_at, addr_trace.size(), coef);
        end
        @(negedge clk);
        start      = 1'b1;
        kernel_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_pulse: error=%b busy=%b, required 1 0", error, busy);
        end
        @(negedge clk);
        total++;
        if (error !== 1'b0 || busy !== 1'b0 || coef !== '0 || kernel_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL err_after: error=%b busy=%b valid=%b coef=%h, required 0 0 1 0",
                     error, busy, kernel_valid, coef);
        end
    endtask

    // start held for 15 cycles: one fetch of KSIZE+1 cycles, one done cycle,
    // then the second acceptance on the first IDLE cycle.
    task automatic test_back_to_back();
        int rises = 0;
        int first_rise = -1;
        int second_rise = -1;
        int dones = 0;
        logic prev_busy = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        kernel_sel = 2'd1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 15) start = 1'b0;
            if (busy === 1'b1 && !prev_busy) begin
                rises++;
                if (rises == 1) first_rise = k;
                if (rises == 2) second_rise = k;
            end
            prev_busy = (busy === 1'b1);
            if (done === 1'b1) dones++;
        end
        total++;
        if (rises != 2 || first_rise != 1 || second_rise != 1 + (KSIZE + 1) + 1) begin
            bad++;
            $display("[TB] FAIL b2b_accept: %0d fetches starting %0d/%0d, required 2 at 1/%0d",
                     rises, first_rise, second_rise, 1 + (KSIZE + 1) + 1);
        end
        total++;
        if (dones != 2 || coef !== model_kernel(1)) begin
            bad++;
            $display("[TB] FAIL b2b_done: %0d done pulses coef=%h, required 2 and %h",
                     dones, coef, model_kernel(1));
        end
    endtask

    task automatic test_reset_midfetch();
        int done_at;
        logic vf, vd;
        @(negedge clk);
        start      = 1'b1;
        kernel_sel = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        total++;
        if (coef !== '0 || kernel_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset: coef=%h valid=%b busy=%b addr=%0d, required 0",
                     coef, kernel_valid, busy, mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        run_fetch(2'd0, done_at, vf, vd);
        total++;
        if (done_at != 10 || coef !== model_kernel(0) || vd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart: done at %0d valid=%b coef=%h, required 10 1 %h",
                     done_at, vd, coef, model_kernel(0));
        end
    endtask

    task automatic test_random();
        int done_at;
        logic vf, vd;
        int sel;
        logic [KSIZE*WIDTH-1:0] model_coef;
        model_coef = model_kernel(0);
        for (int i = 0; i < BASE_ADDR + NKERNELS * KSIZE; i++) mem[i] = WIDTH'($urandom);
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = $urandom_range(0, 3);
            if (sel < NKERNELS) begin
                run_fetch(2'(sel), done_at, vf, vd);
                model_coef = model_kernel(sel);
                total++;
                if (done_at != 10 || !trace_ok(sel) || coef !== model_coef || vf !== 1'b0 || vd !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL rand_fetch sel=%0d: done at %0d addrs=%0d valid=%b/%b coef=%h, required 10 9 0/1 %h",
                             sel, done_at, addr_trace.size(), vf, vd, coef, model_coef);
                end
            end else begin
                @(negedge clk);
                start      = 1'b1;
                kernel_sel = 2'(sel);
                @(negedge clk);
                start = 1'b0;
                total++;
                if (error !== 1'b1 || busy !== 1'b0 || coef !== model_coef || kernel_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL rand_error: error=%b busy=%b valid=%b coef=%h, required 1 0 1 %h",
                             error, busy, kernel_valid, coef, model_coef);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        kernel_sel = 2'd0;
        load_production();
        test_reset();
        test_kernel0();
        test_kernel1();
        test_kernel2_and_error();
        test_back_to_back();
        test_reset_midfetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
